addi_serial_unit: RTL
=====================

# addi_serial_unit

Bit-serial execute stage for the CPU's I-type add (ADDI). It accepts a 16-bit source register value and a short signed immediate, sign-extends the immediate, and produces the sum one bit per clock through a single 1-bit full-adder cell. The final sum and carry-out/overflow/zero flags are handed to register writeback with a valid pulse. It sits between the decode/operand-read stage, which is upstream, and writeback, which is downstream.

## Interface
Parameters:
- DATA_W, default 16: operand and result width.
- IMM_W, default 6: width of the raw immediate field, two's complement.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: upstream presents an operand pair.
- in_ready, output, 1: unit can accept; equals (state==IDLE) && rst_n.
- rs, input, DATA_W: source register value (operand A).
- immediate, input, IMM_W: raw signed immediate (operand B before extension).
- out_valid, output, 1: one-cycle pulse; result and flags are valid.
- result, output, DATA_W: sum; holds its value until the next accepted operation completes.
- cout, output, 1: carry out of bit DATA_W-1.
- overflow, output, 1: signed overflow.
- zero, output, 1: result == 0.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE.** On in_valid && in_ready:
  - a_sr <= rs; b_sr <= sign-extend(immediate) to DATA_W; carry <= 0; cnt <= 0; acc <= 0; state <= RUN.
- **RUN**, every cycle:
  - s = a_sr[0] ^ b_sr[0] ^ carry;
  - c_next = majority(a_sr[0], b_sr[0], carry);
  - acc <= {s, acc[DATA_W-1:1]};
  - a_sr and b_sr shift right;
  - carry <= c_next; cnt <= cnt+1.
  - When cnt == DATA_W-2, also latch c_msb_in <= c_next. This is the carry into the MSB.
  - When cnt == DATA_W-1, go to DONE.
- **DONE:**
  - result <= acc; cout <= carry; overflow <= carry ^ c_msb_in; zero <= (acc == 0);
  - out_valid <= 1 for exactly one cycle;
  - state <= IDLE.
- Arithmetic is modulo 2^DATA_W. cnt is $clog2(DATA_W) bits wide and never wraps inside RUN.
- in_valid during RUN or DONE is ignored. Upstream must hold its operands until in_ready is high.
- No backpressure from downstream. Writeback must consume out_valid in the cycle it is asserted.

## Timing
- Reset values: state=IDLE, result=0, cout=0, overflow=0, zero=0, out_valid=0, acc=0, carry=0, cnt=0.
- Reset asserted mid-RUN or in DONE:
  - the operation is aborted with no out_valid;
  - result and flags return to 0;
  - in_ready is high on the first cycle after rst_n rises.
- Latency: accept edge at cycle T; the DATA_W RUN cycles complete at T+DATA_W; out_valid is high during cycle T+DATA_W+1.
- Throughput: one operation per DATA_W+2 cycles. in_ready rises in the same cycle as out_valid, so a back-to-back accept can occur on that cycle's edge.
- Simultaneous in_valid and reset: reset wins and nothing is accepted.

## Configuration
- Macro: ADDI_SERIAL_FLAGS_EN.
- Defined: cout, overflow and zero behave as specified above.
- Undefined:
  - the flag registers and c_msb_in are not built;
  - cout, overflow and zero are tied to 0;
  - result, latency and handshake are unchanged.

## Structure
- Shared package cpu_addi_pkg holds:
  - localparams ADDI_DATA_W=16 and ADDI_IMM_W=6, used as the module defaults;
  - typedef enum addi_state_t {IDLE, RUN, DONE}.
- One sub-module, fa_cell: a combinational 1-bit full adder with inputs a, b, cin and outputs s, cout. It is instantiated once in the RUN datapath.
- Sign extension is a single assign in the top module. No extra module is needed for it.

## Test plan
- rs=0x0005, immediate=6'h03 -> result=0x0008, cout=0, overflow=0, zero=0; out_valid exactly at T+17.
- rs=0x0001, immediate=6'h3F (-1) -> result=0x0000, cout=1, zero=1, overflow=0.
- rs=0x7FFF, immediate=6'h01 -> result=0x8000, overflow=1, cout=0. Also rs=0x8000, immediate=6'h20 (-32) -> result=0x7FE0, overflow=1, cout=1.
- rst_n low for one cycle at T+8 mid-RUN -> no out_valid; result=0; in_ready=1 the cycle after release; a new op then completes normally.
- in_valid held high continuously with changing operands -> accepts occur only at T and T+18; operands presented during RUN are ignored; each result matches its accepted pair.
- Build without ADDI_SERIAL_FLAGS_EN, rs=0xFFFF, immediate=6'h01 -> result=0x0000 with cout=0, overflow=0, zero=0.

Source files
------------

// File: rtl/cpu_addi_pkg.sv
// Shared types and defaults for the bit-serial ADDI execute stage.
// Used by addi_serial_unit and its full-adder cell.
package cpu_addi_pkg;

   localparam int ADDI_DATA_W = 16;
   localparam int ADDI_IMM_W  = 6;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } addi_state_t;

endpackage

// File: rtl/addi_serial_unit_fa_cell.sv
// Single-bit full adder cell for the serial ADDI datapath.
// Purely combinational: one instance is reused every RUN cycle.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addi_serial_unit.sv
// Bit-serial ADDI execute stage: rs + sext(immediate), one bit per clock.
// Flag outputs are built only when ADDI_SERIAL_FLAGS_EN is defined.
module addi_serial_unit
   import cpu_addi_pkg::*;
#(
   parameter int DATA_W = ADDI_DATA_W,
   parameter int IMM_W  = ADDI_IMM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] rs,
   input  logic [IMM_W-1:0]  immediate,
   output logic              out_valid,
   output logic [DATA_W-1:0] result,
   output logic              cout,
   output logic              overflow,
   output logic              zero
);

   localparam int CW = $clog2(DATA_W);

   addi_state_t       state;
   logic [DATA_W-1:0] a_sr;
   logic [DATA_W-1:0] b_sr;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] imm_ext;
   logic              carry;
   logic [CW-1:0]     cnt;
   logic              s;
   logic              c_next;

`ifdef ADDI_SERIAL_FLAGS_EN
   logic c_msb_in;
`endif

   assign imm_ext  = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
   assign in_ready = (state == IDLE) && rst_n;

   fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (s),
      .cout (c_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         out_valid <= 1'b0;
`ifdef ADDI_SERIAL_FLAGS_EN
         c_msb_in  <= 1'b0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= rs;
                  b_sr  <= imm_ext;
                  carry <= 1'b0;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= {s, acc[DATA_W-1:1]};
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= c_next;
               cnt   <= cnt + CW'(1);
`ifdef ADDI_SERIAL_FLAGS_EN
               // carry into the MSB, needed for signed overflow
               if (cnt == CW'(DATA_W-2))
                  c_msb_in <= c_next;
`endif
               if (cnt == CW'(DATA_W-1))
                  state <= DONE;
            end
            DONE: begin
               result    <= acc;
               out_valid <= 1'b1;
`ifdef ADDI_SERIAL_FLAGS_EN
               cout      <= carry;
               overflow  <= carry ^ c_msb_in;
               zero      <= (acc == '0);
`endif
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef ADDI_SERIAL_FLAGS_EN
   assign cout     = 1'b0;
   assign overflow = 1'b0;
   assign zero     = 1'b0;
`endif

endmodule
